// File: rtl/regfile_fwd.sv
// GPR file with per-port EX/MEM/WB operand forwarding, load-use stall detection
// and a saturating stall-cycle counter.
module regfile_fwd #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     ex_wreg,
    input  logic [ADDR_W-1:0]        ex_wd,
    input  logic [DATA_W-1:0]        ex_wdata,
    input  logic                     ex_is_load,
    input  logic                     mem_wreg,
    input  logic [ADDR_W-1:0]        mem_wd,
    input  logic [DATA_W-1:0]        mem_wdata,
    output logic                     stallreq,
    output logic [CNT_W-1:0]         stall_cnt,
    input  logic                     cnt_clr
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] port_addr [NUM_RD];

    for (genvar g = 0; g < NUM_RD; g++) begin : g_addr
        assign port_addr[g] = raddr[g*ADDR_W +: ADDR_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs_q[waddr] <= wdata;
        end
    end

    // A load in EX has no data yet: skip it as a forward source and stall instead.
    always_comb begin
        rdata    = '0;
        stallreq = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (!rst && re[k] && port_addr[k] != '0) begin
                if (ex_wreg && ex_wd == port_addr[k] && !ex_is_load) begin
                    rdata[k*DATA_W +: DATA_W] = ex_wdata;
                end else if (mem_wreg && mem_wd == port_addr[k]) begin
                    rdata[k*DATA_W +: DATA_W] = mem_wdata;
                end else if (we && waddr == port_addr[k]) begin
                    rdata[k*DATA_W +: DATA_W] = wdata;
                end else begin
                    rdata[k*DATA_W +: DATA_W] = regs_q[port_addr[k]];
                end
                if (ex_wreg && ex_is_load && ex_wd == port_addr[k]) begin
                    stallreq = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (stallreq && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_fwd.sv
// Bench for regfile_fwd: directed vector table, multi-cycle stall/counter sequences
// and randomized traffic against a behavioural register-file model.
`timescale 1ns/1ps
module tb_regfile_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata, rdata_b;
    logic        ex_wreg, ex_is_load, mem_wreg, cnt_clr;
    logic [4:0]  ex_wd, mem_wd;
    logic [31:0] ex_wdata, mem_wdata;
    logic        stallreq, stallreq_b;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_fwd dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata),
        .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
        .stallreq(stallreq), .stall_cnt(stall_cnt), .cnt_clr(cnt_clr)
    );

    regfile_fwd #(.CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_b),
        .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
        .stallreq(stallreq_b), .stall_cnt(stall_cnt_b), .cnt_clr(cnt_clr)
    );

    // Behavioural model: plain array plus two integer counters.
    logic [31:0] m_regs [32];
    int          m_cnt, m_cnt4;
    logic        m_st;

    function automatic logic [4:0] ra(int k);
        return raddr[k*5 +: 5];
    endfunction

    function automatic logic port_hazard(int k);
        return !rst && re[k] && ra(k) != 0 && ex_wreg && ex_is_load && ex_wd == ra(k);
    endfunction

    function automatic logic exp_stall();
        return port_hazard(0) || port_hazard(1);
    endfunction

    function automatic logic [31:0] exp_rd(int k);
        logic [4:0] a;
        a = ra(k);
        if (rst || !re[k] || a == 0) return 32'h0;
        if (ex_wreg && ex_wd == a && !ex_is_load) return ex_wdata;
        if (mem_wreg && mem_wd == a) return mem_wdata;
        if (we && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    always @(posedge clk) begin
        m_st = exp_stall();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_cnt  = 0;
            m_cnt4 = 0;
        end else begin
            if (we && waddr != 0) m_regs[waddr] = wdata;
            if (cnt_clr) begin
                m_cnt  = 0;
                m_cnt4 = 0;
            end else if (m_st) begin
                if (m_cnt  != 65535) m_cnt++;
                if (m_cnt4 != 15)    m_cnt4++;
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        we = 0; waddr = 0; wdata = 0; re = 0; raddr = 0;
        ex_wreg = 0; ex_wd = 0; ex_wdata = 0; ex_is_load = 0;
        mem_wreg = 0; mem_wd = 0; mem_wdata = 0; cnt_clr = 0;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  re;
        logic [4:0]  ra0, ra1;
        logic        exw;
        logic [4:0]  exwd;
        logic [31:0] exd;
        logic        exld;
        logic        memw;
        logic [4:0]  memwd;
        logic [31:0] memd;
        logic [31:0] exp0, exp1;
        logic        expst;
    } vec_t;

    vec_t vecs [12];

    initial begin
        idle();
        rst = 1;

        // Each entry occupies one cycle; writes land at the following edge.
        vecs[0]  = '{1, 5, 32'hDEADBEEF, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
        vecs[1]  = '{0, 0, 0,            2'b01, 5, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
        vecs[2]  = '{1, 3, 32'h1,        2'b00, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0,            2'b11, 3, 3, 1, 3, 32'h3, 0, 1, 3, 32'h2, 32'h3, 32'h3, 0};
        vecs[4]  = '{0, 0, 0,            2'b11, 3, 3, 0, 0, 0,     0, 1, 3, 32'h2, 32'h2, 32'h2, 0};
        vecs[5]  = '{0, 0, 0,            2'b11, 3, 3, 0, 0, 0,     0, 0, 0, 0,     32'h1, 32'h1, 0};
        vecs[6]  = '{1, 0, 32'hFFFFFFFF, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[7]  = '{0, 0, 0,            2'b11, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0};
        vecs[8]  = '{0, 0, 0,            2'b11, 0, 0, 1, 0, 32'h9, 1, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{1, 5, 32'h12345678, 2'b10, 0, 5, 0, 0, 0, 0, 1, 5, 32'hAA, 0, 32'hAA, 0};
        vecs[10] = '{0, 0, 0,            2'b11, 3, 5, 0, 0, 0, 0, 0, 0, 0, 32'h1, 32'h12345678, 0};
        vecs[11] = '{0, 0, 0,            2'b10, 0, 3, 1, 3, 32'h7, 0, 0, 0, 0, 0, 32'h7, 0};

        // Reset: outputs forced low while rst is high.
        @(negedge clk);
        re = 2'b11; raddr = {5'd5, 5'd3};
        #1;
        chk("rst_rdata", rdata[31:0], 32'h0);
        chk("rst_stall", {31'h0, stallreq}, 32'h0);
        @(negedge clk);
        rst = 0;
        idle();
        for (int i = 0; i < 32; i++) begin
            re = 2'b11; raddr = {i[4:0], i[4:0]};
            #1;
            chk("init_rd0", rdata[31:0], 32'h0);
            chk("init_rd1", rdata[63:32], 32'h0);
            @(negedge clk);
        end
        chk("init_cnt", {16'h0, stall_cnt}, 32'h0);

        for (int v = 0; v < 12; v++) begin
            idle();
            we = vecs[v].we; waddr = vecs[v].waddr; wdata = vecs[v].wdata;
            re = vecs[v].re; raddr = {vecs[v].ra1, vecs[v].ra0};
            ex_wreg = vecs[v].exw; ex_wd = vecs[v].exwd; ex_wdata = vecs[v].exd;
            ex_is_load = vecs[v].exld;
            mem_wreg = vecs[v].memw; mem_wd = vecs[v].memwd; mem_wdata = vecs[v].memd;
            #1;
            chk($sformatf("vec%0d_rd0", v), rdata[31:0], vecs[v].exp0);
            chk($sformatf("vec%0d_rd1", v), rdata[63:32], vecs[v].exp1);
            chk($sformatf("vec%0d_stall", v), {31'h0, stallreq}, {31'h0, vecs[v].expst});
            @(negedge clk);
        end

        // Load-use on port 1 for three cycles, then clear while still stalling.
        idle(); cnt_clr = 1;
        @(negedge clk);
        idle();
        ex_wreg = 1; ex_is_load = 1; ex_wd = 7; re = 2'b10; raddr = {5'd7, 5'd0};
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("lu_stall", {31'h0, stallreq}, 32'h1);
            @(negedge clk);
        end
        chk("lu_cnt3", {16'h0, stall_cnt}, 32'd3);
        cnt_clr = 1;
        #1;
        chk("lu_clr_stall", {31'h0, stallreq}, 32'h1);
        @(posedge clk); #1;
        chk("lu_clr_cnt", {16'h0, stall_cnt}, 32'h0);

        // Saturation of the narrow counter, then reset in the middle of a stall.
        @(negedge clk);
        cnt_clr = 0;
        repeat (20) @(negedge clk);
        chk("sat_cnt4", {28'h0, stall_cnt_b}, 32'd15);
        chk("sat_cnt16", {16'h0, stall_cnt}, 32'd20);
        rst = 1;
        #1;
        chk("midrst_stall", {31'h0, stallreq}, 32'h0);
        chk("midrst_stall_b", {31'h0, stallreq_b}, 32'h0);
        chk("midrst_rd1", rdata[63:32], 32'h0);
        chk("midrst_cnt_pre", {28'h0, stall_cnt_b}, 32'd15);
        @(posedge clk); #1;
        chk("midrst_cnt", {16'h0, stall_cnt}, 32'h0);
        chk("midrst_cnt_b", {28'h0, stall_cnt_b}, 32'h0);
        @(negedge clk);
        rst = 0;
        idle();

        // Randomized traffic on a narrow address range to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 99) == 0);
            we         = $urandom_range(0, 1);
            waddr      = 5'($urandom_range(0, 7));
            wdata      = $urandom;
            re         = 2'($urandom_range(0, 3));
            raddr      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            ex_wreg    = $urandom_range(0, 1);
            ex_wd      = 5'($urandom_range(0, 7));
            ex_wdata   = $urandom;
            ex_is_load = ($urandom_range(0, 2) == 0);
            mem_wreg   = $urandom_range(0, 1);
            mem_wd     = 5'($urandom_range(0, 7));
            mem_wdata  = $urandom;
            cnt_clr    = ($urandom_range(0, 29) == 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (!port_hazard(k))
                    chk($sformatf("rnd_rd%0d", k), rdata[k*32 +: 32], exp_rd(k));
            end
            chk("rnd_stall", {31'h0, stallreq}, {31'h0, exp_stall()});
            @(posedge clk); #1;
            chk("rnd_cnt", {16'h0, stall_cnt}, m_cnt);
            chk("rnd_cnt4", {28'h0, stall_cnt_b}, m_cnt4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
